adcv_averager: RTL and testbench

Decimating boxcar averager directly downstream of the ramp-ADC (`adcv`) output. It consumes one `digital_out` code per conversion strobe and accumulates 2^LOG2_N consecutive codes. It emits the rounded mean on a one-deep buffered valid/ready output toward the readout logic. Results that cannot be delivered because of back-pressure are dropped and counted.

---
 rtl/adcv_averager.sv | 97 +++++++++
 tb/tb_adcv_averager.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/adcv_averager.sv
// Decimating boxcar averager for the ramp-ADC output stream.
// Averages 2^LOG2_N codes with round-half-up and hands the mean out via a one-deep valid/ready buffer.
module adcv_averager #(
  parameter int unsigned DATA_BITS = 7,
  parameter int unsigned LOG2_N    = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DATA_BITS-1:0] sample_in,
  input  logic                 sample_valid,
  output logic [DATA_BITS-1:0] avg_out,
  output logic                 avg_valid,
  input  logic                 avg_ready,
  output logic [7:0]           overrun_count
);

  localparam int unsigned ACC_W   = DATA_BITS + LOG2_N;
  localparam int unsigned SUM_W   = ACC_W + 1;
  localparam int unsigned CNT_W   = (LOG2_N == 0) ? 1 : LOG2_N;
  localparam int unsigned N       = 1 << LOG2_N;
  localparam int unsigned LAST    = N - 1;
  localparam int unsigned HALF    = N >> 1;
  localparam logic [7:0]  OVR_MAX = 8'hFF;

  logic [ACC_W-1:0]     acc, acc_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [DATA_BITS-1:0] avg_out_n;
  logic                 avg_valid_n;
  logic [7:0]           overrun_count_n;

  logic                 accept_c;
  logic                 complete_c;
  logic                 can_load_c;
  logic [SUM_W-1:0]     sum_c;
  logic [DATA_BITS-1:0] result_c;

  // Window arithmetic; with LOG2_N=0 HALF is 0 and the shift is a pass-through.
  always_comb begin
    accept_c   = enable & sample_valid;
    complete_c = accept_c & (cnt == CNT_W'(LAST));
    can_load_c = ~avg_valid | avg_ready;
    sum_c      = SUM_W'(acc) + SUM_W'(sample_in);
    result_c   = DATA_BITS'((sum_c + SUM_W'(HALF)) >> LOG2_N);
  end

  // Next-state for accumulator, output buffer and overrun counter.
  always_comb begin
    acc_n           = acc;
    cnt_n           = cnt;
    avg_out_n       = avg_out;
    avg_valid_n     = avg_valid;
    overrun_count_n = overrun_count;

    if (!enable) begin
      acc_n = '0;
      cnt_n = '0;
    end else if (accept_c) begin
      if (complete_c) begin
        acc_n = '0;
        cnt_n = '0;
      end else begin
        acc_n = acc + ACC_W'(sample_in);
        cnt_n = cnt + CNT_W'(1);
      end
    end

    if (complete_c && can_load_c) begin
      avg_out_n   = result_c;
      avg_valid_n = 1'b1;
    end else if (avg_valid && avg_ready) begin
      avg_valid_n = 1'b0;
    end

    // A completed window with a stalled, occupied buffer is dropped.
    if (complete_c && !can_load_c && overrun_count != OVR_MAX) begin
      overrun_count_n = overrun_count + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc           <= '0;
      cnt           <= '0;
      avg_out       <= '0;
      avg_valid     <= 1'b0;
      overrun_count <= '0;
    end else begin
      acc           <= acc_n;
      cnt           <= cnt_n;
      avg_out       <= avg_out_n;
      avg_valid     <= avg_valid_n;
      overrun_count <= overrun_count_n;
    end
  end

endmodule

// File: tb/tb_adcv_averager.sv
// Directed bench for adcv_averager: default window, plus LOG2_N=0 and LOG2_N=8 corners.
module tb_adcv_averager;

  logic clock = 1'b0;
  logic reset;

  // Default instance (DATA_BITS=7, LOG2_N=4)
  logic       enable, sample_valid, avg_ready;
  logic [6:0] sample_in, avg_out;
  logic       avg_valid;
  logic [7:0] overrun_count;

  // LOG2_N=0 instance
  logic       b_enable, b_sample_valid, b_avg_ready;
  logic [6:0] b_sample_in, b_avg_out;
  logic       b_avg_valid;
  logic [7:0] b_overrun_count;

  // LOG2_N=8 instance
  logic       c_enable, c_sample_valid, c_avg_ready;
  logic [6:0] c_sample_in, c_avg_out;
  logic       c_avg_valid;
  logic [7:0] c_overrun_count;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clock = ~clock;

  adcv_averager #(.DATA_BITS(7), .LOG2_N(4)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .sample_in(sample_in),
    .sample_valid(sample_valid), .avg_out(avg_out), .avg_valid(avg_valid),
    .avg_ready(avg_ready), .overrun_count(overrun_count)
  );

  adcv_averager #(.DATA_BITS(7), .LOG2_N(0)) dut_b (
    .clock(clock), .reset(reset), .enable(b_enable), .sample_in(b_sample_in),
    .sample_valid(b_sample_valid), .avg_out(b_avg_out), .avg_valid(b_avg_valid),
    .avg_ready(b_avg_ready), .overrun_count(b_overrun_count)
  );

  adcv_averager #(.DATA_BITS(7), .LOG2_N(8)) dut_c (
    .clock(clock), .reset(reset), .enable(c_enable), .sample_in(c_sample_in),
    .sample_valid(c_sample_valid), .avg_out(c_avg_out), .avg_valid(c_avg_valid),
    .avg_ready(c_avg_ready), .overrun_count(c_overrun_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Strobe n samples of value v on back-to-back cycles; sample_valid is left high.
  task automatic strobes(input logic [6:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1;
      sample_in    = v;
      tick();
    end
  endtask

  task automatic idle(input int n);
    sample_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b0;
    enable = 1'b0; sample_valid = 1'b0; sample_in = '0; avg_ready = 1'b1;
    b_enable = 1'b0; b_sample_valid = 1'b0; b_sample_in = '0; b_avg_ready = 1'b1;
    c_enable = 1'b0; c_sample_valid = 1'b0; c_sample_in = '0; c_avg_ready = 1'b1;
    #1;
    check("reset_avg_out", avg_out, 0);
    check("reset_avg_valid", avg_valid, 0);
    check("reset_overrun", overrun_count, 0);
    tick(); tick();
    reset = 1'b1;
    enable = 1'b1; b_enable = 1'b1; c_enable = 1'b1;

    // Constant input
    strobes(7'd100, 15);
    check("const_not_yet", avg_valid, 0);
    strobes(7'd100, 1);
    check("const_valid", avg_valid, 1);
    check("const_out", avg_out, 100);
    idle(1);
    check("const_drained", avg_valid, 0);
    check("const_hold_out", avg_out, 100);

    // Rounding: 168 -> 11, 167 -> 10
    strobes(7'd10, 8);
    strobes(7'd11, 8);
    check("round_up_valid", avg_valid, 1);
    check("round_up_out", avg_out, 11);
    strobes(7'd10, 15);
    strobes(7'd17, 1);
    check("round_down_valid", avg_valid, 1);
    check("round_down_out", avg_out, 10);
    idle(1);

    // Full scale, back-to-back windows
    strobes(7'd127, 16);
    check("full_out", avg_out, 127);
    check("full_valid", avg_valid, 1);
    strobes(7'd127, 15);
    check("full_gap_valid", avg_valid, 0);
    strobes(7'd127, 1);
    check("full_second_valid", avg_valid, 1);
    check("full_second_out", avg_out, 127);
    idle(1);
    check("full_drained", avg_valid, 0);

    // Back-pressure and single overrun
    avg_ready = 1'b0;
    strobes(7'd20, 16);
    check("bp_a_valid", avg_valid, 1);
    check("bp_a_out", avg_out, 20);
    strobes(7'd40, 8);
    check("bp_mid_out", avg_out, 20);
    strobes(7'd40, 8);
    check("bp_b_out", avg_out, 20);
    check("bp_b_valid", avg_valid, 1);
    check("bp_overrun", overrun_count, 1);
    avg_ready = 1'b1;
    idle(1);
    check("bp_drained", avg_valid, 0);
    check("bp_drain_out", avg_out, 20);

    // Overrun saturation: one load then 255 drops
    avg_ready = 1'b0;
    strobes(7'd5, 16);
    check("sat_load_out", avg_out, 5);
    check("sat_load_overrun", overrun_count, 1);
    for (int w = 0; w < 255; w++) strobes(7'd90, 16);
    check("sat_overrun", overrun_count, 255);
    check("sat_kept_out", avg_out, 5);
    avg_ready = 1'b1;
    idle(1);
    check("sat_drained", avg_valid, 0);

    // Enable abort: partial window of 127s must not leak into the 50 window
    strobes(7'd127, 5);
    enable = 1'b0;
    strobes(7'd127, 3);
    check("abort_no_result", avg_valid, 0);
    check("abort_overrun_hold", overrun_count, 255);
    enable = 1'b1;
    strobes(7'd50, 11);
    check("abort_no_early", avg_valid, 0);
    strobes(7'd50, 4);
    check("abort_not_yet", avg_valid, 0);
    strobes(7'd50, 1);
    check("abort_valid", avg_valid, 1);
    check("abort_out", avg_out, 50);

    // Asynchronous reset between edges with a result pending and a partial window
    avg_ready = 1'b0;
    strobes(7'd30, 9);
    check("pre_reset_valid", avg_valid, 1);
    sample_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("async_avg_out", avg_out, 0);
    check("async_avg_valid", avg_valid, 0);
    check("async_overrun", overrun_count, 0);
    tick();
    reset = 1'b1;
    avg_ready = 1'b1;
    strobes(7'd64, 16);
    check("post_reset_valid", avg_valid, 1);
    check("post_reset_out", avg_out, 64);

    // Completion and drain in the same cycle
    avg_ready = 1'b0;
    strobes(7'd8, 15);
    check("cd_held_out", avg_out, 64);
    avg_ready = 1'b1;
    strobes(7'd8, 1);
    check("cd_valid", avg_valid, 1);
    check("cd_out", avg_out, 8);
    check("cd_no_overrun", overrun_count, 0);
    idle(1);
    enable = 1'b0;

    // LOG2_N=0: every strobe passes through one edge later
    begin
      logic [6:0] vals [4];
      vals[0] = 7'd0; vals[1] = 7'd1; vals[2] = 7'd77; vals[3] = 7'd127;
      for (int i = 0; i < 4; i++) begin
        b_sample_valid = 1'b1;
        b_sample_in    = vals[i];
        tick();
        check("n1_valid", b_avg_valid, 1);
        check("n1_out", b_avg_out, 32'(vals[i]));
      end
      b_sample_valid = 1'b0;
      tick();
      check("n1_drained", b_avg_valid, 0);
    end

    // LOG2_N=8: 256 x 1 averages to 1
    c_sample_in = 7'd1;
    c_sample_valid = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    check("n256_not_yet", c_avg_valid, 0);
    tick();
    check("n256_valid", c_avg_valid, 1);
    check("n256_out", c_avg_out, 1);
    c_sample_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
